throw_ctrl: RTL and testbench

//  Local-player throw generator; the producer side of the turn protocol consumed by the turn manager.
//  On this player's turn it charges throw power from a mouse button hold and launches on release.
//  It sends a power byte to the remote board (UART TX), then drives throw_flag high for the flight.
//  The throw_flag falling edge is the turn-advance event; the turn counter is fed back on turn[2:0].

---
 rtl/throw_ctrl.sv | 154 +++++++++++++++
 tb/tb_throw_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/throw_ctrl.sv
// throw_ctrl: local-player throw generator.
// Charges power while the mouse button is held on this player's turn and
// launches on release. The power byte goes out over the UART TX handshake,
// then throw_flag is held high for the flight.
// Optional feature: define THROW_TIMEOUT_EN to auto-throw at half power
// after TIMEOUT_CYC idle cycles on this player's turn.
module throw_ctrl #(
   parameter int MY_PARITY     = 1,
   parameter int POWER_MAX     = 100,
   parameter int CHARGE_DIV    = 600_000,
   parameter int FLIGHT_CYCLES = 60_000_000,
   parameter int TIMEOUT_CYC   = 600_000_000
) (
   input  logic       clk60MHz,
   input  logic       rst_n,
   input  logic [2:0] turn,
   input  logic       mouse_left,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       throw_flag,
   output logic [6:0] power,
   output logic       charging
);

   localparam int DW = (CHARGE_DIV    > 1) ? $clog2(CHARGE_DIV)    : 1;
   localparam int FW = (FLIGHT_CYCLES > 1) ? $clog2(FLIGHT_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, CHARGE, LAUNCH, FLIGHT, DONE} state_t;

   state_t          state, state_n;
   logic [6:0]      power_n;
   logic [DW-1:0]   div_q, div_n;
   logic [FW-1:0]   flt_q, flt_n;
   logic [2:0]      turn_lat, turn_lat_n;
   logic            btn_q;
   logic            my_turn, btn_rise, btn_fall;

`ifdef THROW_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TW-1:0]   tmo_q, tmo_n;
`endif

   assign my_turn  = (turn[0] == MY_PARITY[0]);
   assign btn_rise = mouse_left & ~btn_q;
   assign btn_fall = ~mouse_left & btn_q;

   // State register
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Datapath registers. btn_q resets high so a button held through reset
   // produces no rise until it is released and pressed again.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         btn_q    <= 1'b1;
         power    <= '0;
         div_q    <= '0;
         flt_q    <= '0;
         turn_lat <= '0;
`ifdef THROW_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         btn_q    <= mouse_left;
         power    <= power_n;
         div_q    <= div_n;
         flt_q    <= flt_n;
         turn_lat <= turn_lat_n;
`ifdef THROW_TIMEOUT_EN
         tmo_q    <= tmo_n;
`endif
      end
   end

   // Next-state, datapath updates and state-decoded outputs
   always_comb begin
      state_n    = state;
      power_n    = power;
      div_n      = div_q;
      flt_n      = flt_q;
      turn_lat_n = turn_lat;
`ifdef THROW_TIMEOUT_EN
      tmo_n      = '0;
`endif
      tx_valid   = 1'b0;
      throw_flag = 1'b0;
      charging   = 1'b0;
      tx_data    = 8'h00;
      case (state)
         IDLE: begin
            if (my_turn && btn_rise) begin
               state_n = CHARGE;
               power_n = '0;
               div_n   = '0;
            end
`ifdef THROW_TIMEOUT_EN
            else if (my_turn) begin
               if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                  state_n = LAUNCH;
                  power_n = 7'(POWER_MAX / 2);
               end else begin
                  tmo_n = tmo_q + 1'b1;
               end
            end
`endif
         end
         CHARGE: begin
            charging = 1'b1;
            if (btn_fall) begin
               // a zero-power release still sends power 1
               state_n = LAUNCH;
               power_n = (power == 7'd0) ? 7'd1 : power;
            end else if (!my_turn) begin
               state_n = IDLE;
               power_n = '0;
            end else if (div_q == DW'(CHARGE_DIV - 1)) begin
               div_n = '0;
               if (power < 7'(POWER_MAX)) power_n = power + 7'd1;
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         LAUNCH: begin
            tx_valid = 1'b1;
            tx_data  = {1'b1, power};
            if (tx_ready) begin
               state_n = FLIGHT;
               flt_n   = '0;
            end
         end
         FLIGHT: begin
            throw_flag = 1'b1;
            if (flt_q == FW'(FLIGHT_CYCLES - 1)) begin
               state_n    = DONE;
               turn_lat_n = turn;
            end else begin
               flt_n = flt_q + 1'b1;
            end
         end
         DONE: begin
            // turn manager advances one cycle after the throw_flag fall
            if (turn != turn_lat) begin
               state_n = IDLE;
               power_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_throw_ctrl.sv
// Scoreboard bench for throw_ctrl: stimulus pushes expected throw bytes,
// a negedge monitor checks every TX handshake and the following flight.
module tb_throw_ctrl;

   localparam int POWER_MAX     = 10;
   localparam int CHARGE_DIV    = 4;
   localparam int FLIGHT_CYCLES = 20;
   localparam int TIMEOUT_CYC   = 200;

   logic       clk60MHz = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] turn = 3'd1;
   logic       mouse_left = 1'b0;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid, throw_flag, charging;
   logic [6:0] power;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk60MHz = ~clk60MHz;

   throw_ctrl #(
      .MY_PARITY(1), .POWER_MAX(POWER_MAX), .CHARGE_DIV(CHARGE_DIV),
      .FLIGHT_CYCLES(FLIGHT_CYCLES), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk60MHz(clk60MHz), .rst_n(rst_n), .turn(turn), .mouse_left(mouse_left),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .throw_flag(throw_flag), .power(power), .charging(charging)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference: one power step per CHARGE_DIV held cycles after the press cycle
   function automatic logic [7:0] exp_byte(input int hold);
      int p;
      p = (hold - 1) / CHARGE_DIV;
      if (p > POWER_MAX) p = POWER_MAX;
      if (p < 1) p = 1;
      return 8'h80 | 8'(p);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk60MHz);
      #1;
   endtask

   // monitor: handshake -> pop and compare; flag must follow next cycle and
   // last exactly FLIGHT_CYCLES; no flag outside a flight
   logic       prev_v = 1'b0;
   logic [7:0] prev_d = 8'h00;
   bit         hs_pend = 0, in_fl = 0;
   int         fl_len = 0;
   always @(negedge clk60MHz) begin
      if (!rst_n) begin
         prev_v = 1'b0; hs_pend = 0; in_fl = 0; fl_len = 0;
      end else begin
         if (hs_pend) begin
            chk("flag_rise", throw_flag, 1);
            chk("valid_drop", tx_valid, 0);
            hs_pend = 0; in_fl = 1; fl_len = 0;
         end
         if (in_fl) begin
            if (throw_flag) fl_len++;
            else begin
               chk("flight_len", fl_len, FLIGHT_CYCLES);
               in_fl = 0;
            end
         end else begin
            chk("stray_flag", throw_flag, 0);
         end
         if (tx_valid) begin
            if (prev_v) chk("tx_stable", tx_data, prev_d);
            if (tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_tx: got %0h expected no send", tx_data);
               end else begin
                  chk("tx_data", tx_data, exp_q.pop_front());
               end
               hs_pend = 1;
            end
         end
         prev_v = tx_valid && !tx_ready;
         prev_d = tx_data;
      end
   end

   task automatic wait_flight();
      int n;
      n = 0;
      while (!throw_flag && n < TIMEOUT_CYC + 50) begin cyc(1); n++; end
      chk("flag_seen", throw_flag, 1);
      n = 0;
      while (throw_flag && n < FLIGHT_CYCLES + 5) begin cyc(1); n++; end
      chk("flag_end", throw_flag, 0);
   endtask

   // full turn: charge, launch with delayed ready, flight, hand turn over,
   // then some ignored presses on the other player's turn
   task automatic throw(input int hold, input int rdy_wait);
      tx_ready = 1'b0;
      mouse_left = 1'b1;
      cyc(1);
      chk("charging", charging, 1);
      if (hold > 1) cyc(hold - 1);
      mouse_left = 1'b0;
      exp_q.push_back(exp_byte(hold));
      cyc(1);
      chk("launch_valid", tx_valid, 1);
      cyc(rdy_wait);
      chk("flag_before_hs", throw_flag, 0);
      tx_ready = 1'b1;
      cyc(3);
      mouse_left = 1'($urandom_range(0, 1));
      cyc(2);
      mouse_left = 1'b0;
      wait_flight();
      tx_ready = 1'($urandom_range(0, 1));
      turn = turn + 3'd1;
      cyc(2);
      chk("power_cleared", power, 0);
      repeat ($urandom_range(1, 3)) begin
         mouse_left = 1'b1; cyc($urandom_range(1, 8));
         mouse_left = 1'b0; cyc($urandom_range(1, 8));
      end
      turn = turn + 3'd1;
      cyc(2);
   endtask

   initial begin
      #2;
      chk("reset_outputs", {tx_valid, throw_flag, charging, power, tx_data}, 0);
      @(posedge clk60MHz); #1;
      rst_n = 1'b1;
      cyc(2);
      chk("idle_charging", charging, 0);

      throw(1, 0);           // tap -> power 1
      throw(10, 2);          // 2 steps
      throw(60, 1);          // saturates at POWER_MAX
      throw(5, 50);          // long tx_ready stall
      for (int i = 0; i < 12; i++) throw($urandom_range(1, 60), $urandom_range(0, 8));

      // abort: turn leaves mid-charge
      mouse_left = 1'b1; cyc(6);
      turn = turn + 3'd1; cyc(1);
      chk("abort_charging", charging, 0);
      chk("abort_power", power, 0);
      mouse_left = 1'b0; cyc(5);
      turn = turn + 3'd1; cyc(3);

      // button held across turn start is ignored
      turn = turn + 3'd1;
      mouse_left = 1'b1; cyc(3);
      turn = turn + 3'd1; cyc(5);
      chk("held_turn_charging", charging, 0);
      mouse_left = 1'b0; cyc(5);
      throw(9, 1);

      // reset mid-flight, button held across reset
      tx_ready = 1'b1;
      mouse_left = 1'b1; cyc(2); mouse_left = 1'b0;
      exp_q.push_back(exp_byte(2));
      cyc(8);
      chk("midflight_flag", throw_flag, 1);
      #2 rst_n = 1'b0;
      mouse_left = 1'b1;
      #1;
      chk("async_reset_outputs", {tx_valid, throw_flag, charging, power, tx_data}, 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(5);
      chk("held_reset_charging", charging, 0);
      mouse_left = 1'b0; cyc(5);
      chk("held_reset_valid", tx_valid, 0);
      throw(14, 0);

`ifdef THROW_TIMEOUT_EN
      tx_ready = 1'b1;
      exp_q.push_back(8'h80 | 8'(POWER_MAX / 2));
      wait_flight();
      turn = turn + 3'd1; cyc(5);
      turn = turn + 3'd1; cyc(3);
`else
      tx_ready = 1'b1;
      cyc(3 * TIMEOUT_CYC);
      chk("no_timeout_flag", throw_flag, 0);
`endif

      cyc(5);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
